instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the MIPS stub datapath: holds the PC and fetches 32-bit instructions through a request/ready handshake with instruction memory. It buffers one instruction for decode and presents its 16-bit immediate field to the sign extender. It consumes the sign-extended branch offset back from the extender and the decode redirect signals to compute branch and jump targets. There are no delay slots: a redirect squashes any younger fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  32  fetch address; equals the internal PC register.
- imem_req  output  1  fetch request.
- imem_rdata  input  32  instruction word; valid in the cycle where imem_ready=1.
- imem_ready  input  1  memory accepts the request and returns data in the same cycle.
- stall  input  1  decode cannot consume the buffered instruction this cycle.
- branch_taken  input  1  branch redirect for the buffered instruction.
- branch_offset  input  32  sign-extended immediate from the sign extender, in words.
- jump  input  1  jump redirect for the buffered instruction.
- jump_target  input  26  J-type target field.
- instr  output  32  buffered instruction.
- instr_valid  output  1  instr holds a live instruction.
- pc_plus4  output  32  address of the buffered instruction + 4.
- imm  output  16  instr[15:0], routed to the sign extender.
- rs, rt, rd  output  5 each  instr[25:21], instr[20:16], instr[15:11].

## Operation
- Reset behaviour:
  - Reset is asynchronous, active-high.
  - Reset values: pc=RESET_PC, instr=0, instr_valid=0, pc_plus4=0, state=BOOT.
  - imem_req=0 while state=BOOT.
- States:
  - BOOT: no request; goes to FETCH on the next edge.
  - FETCH: requests are issued.
  - BUBBLE: one idle cycle after a redirect; no request; goes to FETCH on the next edge.
- Request and acceptance:
  - imem_req = (state==FETCH) && (!instr_valid || !stall), so a request is made only when the buffer slot is free or being freed this cycle.
  - accept = imem_req && imem_ready.
  - consume = instr_valid && !stall.
  - redirect = consume && (branch_taken || jump). branch_taken and jump are ignored when consume=0.
- Priority per edge: reset, then redirect, then accept, then consume.
  - Redirect: pc <= target; instr_valid <= 0; any accepted word this cycle is discarded; state <= BUBBLE.
  - Accept: instr <= imem_rdata; pc_plus4 <= pc+4; pc <= pc+4; instr_valid <= 1.
  - Consume without accept: instr_valid <= 0. instr is retained but is not live.
  - stall with instr_valid=1: instr, pc_plus4 and pc hold; imem_req=0.
- Targets:
  - Branch target = pc_plus4 + (branch_offset << 2). Bits shifted out above bit 31 are dropped; addition is mod 2^32.
  - Jump target = {pc_plus4[31:28], jump_target, 2'b00}.
  - jump wins if asserted together with branch_taken.
- Wrap-around: pc=32'hFFFF_FFFC accepted gives next pc=0 and pc_plus4=0.
- imem_req low, or imem_ready low, leaves pc unchanged. A pending request keeps imem_addr stable until it is accepted or a redirect occurs.

## Timing
- Fetch latency: request in cycle N with imem_ready=1 gives instr_valid=1 in N+1.
- Throughput: one instruction per cycle with ready held high and no stall.
- Redirect penalty:
  - Redirect sampled at edge N.
  - N+1 is BUBBLE with imem_req=0.
  - The target request is issued in N+2; target instruction valid in N+3.
- First request after reset deasserts: the first edge goes BOOT to FETCH, and the request is at RESET_PC in the following cycle.
- Outputs are registered, except:
  - imem_req is combinational from state, instr_valid and stall.
  - imm, rs, rt and rd are wires from instr.
- rst asserted mid-operation clears instr_valid and state immediately. A request in progress is abandoned; memory is expected to ignore it.

## Test plan
- Reset and streaming:
  - Stimulus: RESET_PC=0, ready=1, no stall; memory word = address.
  - Response: instr = 0, 4, 8, ... on consecutive cycles; pc_plus4 = instr+4; imm = instr[15:0].
- Memory wait states:
  - Stimulus: imem_ready low for 3 cycles at address 0x10.
  - Response: imem_addr holds 0x10 and instr_valid stays 0 until ready; pc advances by exactly 4.
- Stall hold:
  - Stimulus: stall=1 for 4 cycles with instr 0x2008FFFF buffered.
  - Response: imem_req=0; instr, imm=0xFFFF and pc_plus4 stay constant; resumes at the next address after release.
- Backward branch:
  - Stimulus: pc_plus4=0x104, branch_offset=0xFFFF_FFFE, branch_taken=1.
  - Response: next imem_addr=0xFC after one bubble; the word accepted in the redirect cycle is dropped.
- Jump versus branch:
  - Stimulus: pc_plus4=0x4000_0010, jump=1 and branch_taken=1, jump_target=26'h000_0040.
  - Response: fetch from 0x4000_0100.
- Wrap and async reset:
  - Wrap stimulus: fetch at 0xFFFF_FFFC. Response: next address 0, pc_plus4=0.
  - Reset stimulus: rst pulsed mid-stream between edges. Response: instr_valid=0 and imem_req=0 immediately; restart from RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches through a request/ready
// handshake, buffers one instruction for decode and resolves branch/jump
// redirects from decode with a single bubble cycle and no delay slots.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_plus4,
  output logic [15:0] imm,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_inc;
  logic [XLEN-1:0]   offset_bytes;
  logic [XLEN-1:0]   branch_target;
  logic [XLEN-1:0]   jump_addr;
  logic [XLEN-1:0]   redirect_target;
  logic              accept;
  logic              consume;
  logic              redirect;

  // Handshake qualifiers; redirects only count when decode consumes the slot
  assign accept   = imem_req && imem_ready;
  assign consume  = instr_valid && !stall;
  assign redirect = consume && (branch_taken || jump);

  // Target arithmetic; offset is in words and wraps modulo 2^32
  assign pc_inc          = pc + XLEN'(4);
  assign offset_bytes    = branch_offset << 2;
  assign branch_target   = pc_plus4 + offset_bytes;
  assign jump_addr       = {pc_plus4[31:28], jump_target, 2'b00};
  assign redirect_target = jump ? jump_addr : branch_target;

  // Decode field taps feeding the sign extender and register file
  assign imm = instr[15:0];
  assign rs  = instr[25:21];
  assign rt  = instr[20:16];
  assign rd  = instr[15:11];

  assign imem_addr = pc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and request generation; a redirect always forces a bubble
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = !instr_valid || !stall;
      end
      BUBBLE: begin
        state_next = FETCH;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
    if (redirect) begin
      state_next = BUBBLE;
    end
  end

  // PC and instruction buffer: redirect beats accept beats consume
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc_plus4    <= '0;
    end else if (redirect) begin
      pc          <= redirect_target;
      instr_valid <= 1'b0;
    end else if (accept) begin
      instr       <= imem_rdata;
      pc_plus4    <= pc_inc;
      pc          <= pc_inc;
      instr_valid <= 1'b1;
    end else if (consume) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a transaction-level model tracks PC, buffer and
// idle cycles; every negedge compares the DUT against it, and directed
// scenarios add hand-computed literal expectations.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'h0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_plus4;
  logic [15:0] imm;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;

  int checks = 0;
  int errors = 0;

  // Memory returns the address as data, except one patched word
  logic [31:0] ovr_addr = 32'hFFFF_FFF0;
  logic [31:0] ovr_data = 32'hFFFF_FFF0;

  always_comb imem_rdata = (imem_addr == ovr_addr) ? ovr_data : imem_addr;

  instr_fetch dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_target(jump_target),
    .instr(instr), .instr_valid(instr_valid), .pc_plus4(pc_plus4),
    .imm(imm), .rs(rs), .rt(rt), .rd(rd)
  );

  always #5 clk = ~clk;

  // Model state: next fetch address, buffered word, cycles left before fetching
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pp4   = 32'h0;
  logic        m_valid = 1'b0;
  int          m_idle  = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == ovr_addr) ? ovr_data : a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic        req;
    logic        acc;
    logic        cons;
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_idle = 1;
    end else begin
      req  = (m_idle == 0) && (!m_valid || !stall);
      acc  = req && imem_ready;
      cons = m_valid && !stall;
      if (m_idle > 0) m_idle--;
      if (cons && (branch_taken || jump)) begin
        if (jump) tgt = (m_pp4 & 32'hF000_0000) + 32'(jump_target) * 32'd4;
        else      tgt = m_pp4 + branch_offset * 32'd4;
        m_pc = tgt; m_valid = 1'b0; m_idle = 1;
      end else if (acc) begin
        m_instr = mem_word(m_pc);
        m_pp4   = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
        m_valid = 1'b1;
      end else if (cons) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Model advances on every clock edge and on the reset edge
  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Compare process, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("req",   32'(imem_req), 32'((m_idle == 0) && (!m_valid || !stall)));
      check("addr",  imem_addr, m_pc);
      check("valid", 32'(instr_valid), 32'(m_valid));
      check("instr", instr, m_instr);
      check("pp4",   pc_plus4, m_pp4);
      check("imm",   32'(imm), m_instr % 32'h1_0000);
      check("rs",    32'(rs), (m_instr / 32'h20_0000) % 32);
      check("rt",    32'(rt), (m_instr / 32'h1_0000) % 32);
      check("rd",    32'(rd), (m_instr / 32'h800) % 32);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pp4(input logic [31:0] target, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (instr_valid && pc_plus4 == target) return;
      tick();
    end
    check("wait_pp4_timeout", pc_plus4, target);
  endtask

  task automatic branch_redirect(input logic [31:0] off);
    branch_taken = 1'b1; branch_offset = off;
    tick();
    branch_taken = 1'b0; branch_offset = 32'h0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_req",   32'(imem_req), 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_pp4",   pc_plus4, 32'h0);
    rst = 1'b0;
    tick();
    check("boot_req",  32'(imem_req), 32'h1);
    check("boot_addr", imem_addr, 32'h0);
    tick();
    check("first_instr", instr, 32'h0);
    check("first_pp4",   pc_plus4, 32'h4);
    check("first_addr",  imem_addr, 32'h4);
    tick();
    check("stream_instr", instr, 32'h4);
    check("stream_imm",   32'(imm), 32'h4);

    // Memory wait states at 0x10
    wait_pp4(32'h10, 20);
    imem_ready = 1'b0;
    repeat (3) begin
      tick();
      check("wait_addr",  imem_addr, 32'h10);
      check("wait_valid", 32'(instr_valid), 32'h0);
    end
    imem_ready = 1'b1;
    tick();
    check("wait_instr", instr, 32'h10);
    check("wait_next",  imem_addr, 32'h14);

    // Stall hold; redirect requests during stall must be ignored
    ovr_addr = 32'h20; ovr_data = 32'h2008_FFFF;
    wait_pp4(32'h24, 20);
    check("stall_instr", instr, 32'h2008_FFFF);
    check("stall_rt",    32'(rt), 32'h8);
    stall = 1'b1; branch_taken = 1'b1; branch_offset = 32'h100;
    repeat (4) begin
      #1;
      check("stall_req",  32'(imem_req), 32'h0);
      check("stall_imm",  32'(imm), 32'hFFFF);
      check("stall_pp4",  pc_plus4, 32'h24);
      check("stall_addr", imem_addr, 32'h24);
      tick();
    end
    stall = 1'b0; branch_taken = 1'b0; branch_offset = 32'h0;
    tick();
    check("resume_instr", instr, 32'h24);
    check("resume_pp4",   pc_plus4, 32'h28);

    // Backward branch from 0x100
    wait_pp4(32'h104, 200);
    branch_redirect(32'hFFFF_FFFE);
    check("br_bubble_req",   32'(imem_req), 32'h0);
    check("br_bubble_valid", 32'(instr_valid), 32'h0);
    check("br_addr",         imem_addr, 32'h0000_00FC);
    tick();
    check("br_req",  32'(imem_req), 32'h1);
    check("br_addr2", imem_addr, 32'h0000_00FC);
    tick();
    check("br_instr", instr, 32'h0000_00FC);

    // Branch far forward to 0x4000_000C, then jump beats branch
    branch_redirect(32'h0FFF_FFC3);
    check("far_addr", imem_addr, 32'h4000_000C);
    wait_pp4(32'h4000_0010, 10);
    jump = 1'b1; branch_taken = 1'b1; branch_offset = 32'h1; jump_target = 26'h000_0040;
    tick();
    jump = 1'b0; branch_taken = 1'b0; branch_offset = 32'h0; jump_target = 26'h0;
    check("jmp_addr", imem_addr, 32'h4000_0100);
    tick(); tick();
    check("jmp_instr", instr, 32'h4000_0100);

    // Wrap-around at the top of the address space
    wait_pp4(32'h4000_0104, 10);
    branch_redirect(32'h2FFF_FFBE);
    check("wrap_target", imem_addr, 32'hFFFF_FFFC);
    tick(); tick();
    check("wrap_instr", instr, 32'hFFFF_FFFC);
    check("wrap_pp4",   pc_plus4, 32'h0);
    check("wrap_addr",  imem_addr, 32'h0);
    tick(); tick();

    // Asynchronous reset pulse between edges
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(instr_valid), 32'h0);
    check("arst_req",   32'(imem_req), 32'h0);
    check("arst_addr",  imem_addr, 32'h0);
    rst = 1'b0;
    tick();
    check("arst_boot_req", 32'(imem_req), 32'h1);
    wait_pp4(32'h4, 10);
    check("arst_instr", instr, 32'h0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
